// File: rtl/lcd_bus_responder.sv
// Receiver end of an 8080-style parallel LCD bus. It models the ILI9341 write path:
// it tracks the CASET/PASET window and streams one (x, y, rgb565) beat per RAMWR pixel.
module lcd_bus_responder #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [15:0] DEF_EC      = 16'd239,
   parameter logic [15:0] DEF_EP      = 16'd319
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        lcd_res_n,
   input  logic        lcd_csx,
   input  logic        lcd_wrx,
   input  logic        lcd_rdx,
   input  logic        lcd_dcx,
   input  logic [15:0] lcd_d,
   output logic        pix_valid,
   output logic [15:0] pix_x,
   output logic [15:0] pix_y,
   output logic [15:0] pix_data,
   output logic        frame_done,
   output logic        cmd_valid,
   output logic [7:0]  cmd_code,
   output logic        proto_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_CASET, ST_PASET, ST_RAMWR} state_t;

   // Bit layout: {res_n, csx, wrx, rdx, dcx, d[15:0]}. The whole bus is delayed as one word.
   localparam logic [20:0] BUS_IDLE = 21'h1E0000;

   logic [20:0] sync_pipe [SYNC_STAGES];
   logic        wrx_prev, rdx_prev;

   logic        res_s, csx_s, wrx_s, rdx_s, dcx_s;
   logic [15:0] d_s;
   logic        wr_evt, rd_evt;

   state_t      state, state_next;
   logic [1:0]  idx, idx_next;
   logic [23:0] param_buf, param_buf_next;
   logic [15:0] sc, ec, sp, ep, sc_next, ec_next, sp_next, ep_next;
   logic [15:0] cx, cy, cx_next, cy_next;

   logic        pix_valid_next, frame_done_next, cmd_valid_next, proto_err_next;
   logic [15:0] pix_x_next, pix_y_next, pix_data_next;
   logic [7:0]  cmd_code_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_pipe[i] <= BUS_IDLE;
         wrx_prev <= 1'b1;
         rdx_prev <= 1'b1;
      end else begin
         sync_pipe[0] <= {lcd_res_n, lcd_csx, lcd_wrx, lcd_rdx, lcd_dcx, lcd_d};
         for (int i = 1; i < SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
         wrx_prev <= wrx_s;
         rdx_prev <= rdx_s;
      end
   end

   assign {res_s, csx_s, wrx_s, rdx_s, dcx_s, d_s} = sync_pipe[SYNC_STAGES-1];
   assign wr_evt = res_s && !csx_s && wrx_s && !wrx_prev;
   assign rd_evt = res_s && !csx_s && !rdx_s && rdx_prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         idx        <= 2'd0;
         param_buf  <= 24'd0;
         sc         <= 16'd0;
         ec         <= DEF_EC;
         sp         <= 16'd0;
         ep         <= DEF_EP;
         cx         <= 16'd0;
         cy         <= 16'd0;
         pix_valid  <= 1'b0;
         pix_x      <= 16'd0;
         pix_y      <= 16'd0;
         pix_data   <= 16'd0;
         frame_done <= 1'b0;
         cmd_valid  <= 1'b0;
         cmd_code   <= 8'd0;
         proto_err  <= 1'b0;
      end else begin
         state      <= state_next;
         idx        <= idx_next;
         param_buf  <= param_buf_next;
         sc         <= sc_next;
         ec         <= ec_next;
         sp         <= sp_next;
         ep         <= ep_next;
         cx         <= cx_next;
         cy         <= cy_next;
         pix_valid  <= pix_valid_next;
         pix_x      <= pix_x_next;
         pix_y      <= pix_y_next;
         pix_data   <= pix_data_next;
         frame_done <= frame_done_next;
         cmd_valid  <= cmd_valid_next;
         cmd_code   <= cmd_code_next;
         proto_err  <= proto_err_next;
      end
   end

   always_comb begin
      state_next      = state;
      idx_next        = idx;
      param_buf_next  = param_buf;
      sc_next         = sc;
      ec_next         = ec;
      sp_next         = sp;
      ep_next         = ep;
      cx_next         = cx;
      cy_next         = cy;
      pix_valid_next  = 1'b0;
      pix_x_next      = pix_x;
      pix_y_next      = pix_y;
      pix_data_next   = pix_data;
      frame_done_next = 1'b0;
      cmd_valid_next  = 1'b0;
      cmd_code_next   = cmd_code;
      proto_err_next  = 1'b0;

      if (!res_s) begin
         state_next    = ST_IDLE;
         idx_next      = 2'd0;
         sc_next       = 16'd0;
         ec_next       = DEF_EC;
         sp_next       = 16'd0;
         ep_next       = DEF_EP;
         cx_next       = 16'd0;
         cy_next       = 16'd0;
         pix_x_next    = 16'd0;
         pix_y_next    = 16'd0;
         pix_data_next = 16'd0;
         cmd_code_next = 8'd0;
      end else begin
         if (rd_evt) proto_err_next = 1'b1;
         if (wr_evt && !dcx_s) begin
            // Any command abandons a partial parameter sequence without touching the window.
            idx_next = 2'd0;
            case (d_s[7:0])
               8'h2A: state_next = ST_CASET;
               8'h2B: state_next = ST_PASET;
               8'h2C: begin
                  if (sc > ec || sp > ep) begin
                     proto_err_next = 1'b1;
                     state_next     = ST_IDLE;
                  end else begin
                     cx_next    = sc;
                     cy_next    = sp;
                     state_next = ST_RAMWR;
                  end
               end
               default: begin
                  cmd_valid_next = 1'b1;
                  cmd_code_next  = d_s[7:0];
                  state_next     = ST_IDLE;
               end
            endcase
         end else if (wr_evt) begin
            case (state)
               ST_CASET, ST_PASET: begin
                  if (idx == 2'd3) begin
                     // The window only changes once all four bytes have arrived.
                     if (state == ST_CASET) begin
                        sc_next = param_buf[23:8];
                        ec_next = {param_buf[7:0], d_s[7:0]};
                     end else begin
                        sp_next = param_buf[23:8];
                        ep_next = {param_buf[7:0], d_s[7:0]};
                     end
                     idx_next   = 2'd0;
                     state_next = ST_IDLE;
                  end else begin
                     param_buf_next = {param_buf[15:0], d_s[7:0]};
                     idx_next       = idx + 2'd1;
                  end
               end
               ST_RAMWR: begin
                  pix_valid_next = 1'b1;
                  pix_x_next     = cx;
                  pix_y_next     = cy;
                  pix_data_next  = d_s;
                  if (cx == ec) begin
                     cx_next = sc;
                     if (cy == ep) begin
                        cy_next         = sp;
                        frame_done_next = 1'b1;
                     end else begin
                        cy_next = cy + 16'd1;
                     end
                  end else begin
                     cx_next = cx + 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
